// File: rtl/axi_dma_wr_if.sv
// AXI4 write-channel bundle (AW/W/B) between the DMA write master and its memory-side responder.
interface axi_dma_wr_if #(
   parameter int AXI_WIDTH_AD = 32,
   parameter int AXI_WIDTH_ID = 4,
   parameter int AXI_WIDTH_DA = 32,
   parameter int AXI_WIDTH_DS = 4
);

   logic                    M_AWVALID;
   logic                    M_AWREADY;
   logic [AXI_WIDTH_AD-1:0] M_AWADDR;
   logic [AXI_WIDTH_ID-1:0] M_AWID;
   logic [7:0]              M_AWLEN;
   logic [2:0]              M_AWSIZE;
   logic [1:0]              M_AWBURST;
   logic [1:0]              M_AWLOCK;
   logic [3:0]              M_AWCACHE;
   logic [2:0]              M_AWPROT;

   logic                    M_WVALID;
   logic                    M_WREADY;
   logic [AXI_WIDTH_DA-1:0] M_WDATA;
   logic [AXI_WIDTH_DS-1:0] M_WSTRB;
   logic                    M_WLAST;
   logic [AXI_WIDTH_ID-1:0] M_WID;

   logic                    M_BVALID;
   logic                    M_BREADY;
   logic [1:0]              M_BRESP;
   logic [AXI_WIDTH_ID-1:0] M_BID;

   modport master (
      output M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST,
             M_AWLOCK, M_AWCACHE, M_AWPROT,
      input  M_AWREADY,
      output M_WVALID, M_WDATA, M_WSTRB, M_WLAST, M_WID,
      input  M_WREADY,
      input  M_BVALID, M_BRESP, M_BID,
      output M_BREADY
   );

   modport slave (
      input  M_AWVALID, M_AWADDR, M_AWID, M_AWLEN, M_AWSIZE, M_AWBURST,
             M_AWLOCK, M_AWCACHE, M_AWPROT,
      output M_AWREADY,
      input  M_WVALID, M_WDATA, M_WSTRB, M_WLAST, M_WID,
      output M_WREADY,
      output M_BVALID, M_BRESP, M_BID,
      input  M_BREADY
   );

endinterface

// File: rtl/axi_dma_wr.sv
// AXI4 write-master DMA channel: buffers a word stream in a FIFO and drains it as
// fully-buffered INCR bursts that never cross a 4 KB page, one burst outstanding at a time.
module axi_dma_wr #(
   parameter int AXI_WIDTH_AD = 32,
   parameter int AXI_WIDTH_ID = 4,
   parameter int AXI_WIDTH_DA = 32,
   parameter int AXI_WIDTH_DS = 4,
   parameter int MAX_BURST    = 16,
   parameter int FIFO_DEPTH   = 32
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [AXI_WIDTH_AD-1:0] base_addr,
   input  logic [31:0]             num_words,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [AXI_WIDTH_DA-1:0] in_data,
   axi_dma_wr_if.master            m_axi
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ADDR,
      S_DATA,
      S_RESP,
      S_DONE
   } state_t;

   state_t                  r_state;
   logic [AXI_WIDTH_AD-1:0] r_addr;
   logic [31:0]             r_rem;
   logic [31:0]             r_acc;
   logic [8:0]              r_len;
   logic [7:0]              r_awLen;
   logic [8:0]              r_beat;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;
   logic                    r_awValid;
   logic                    r_wValid;
   logic                    r_wLast;
   logic                    r_bReady;

   logic [AXI_WIDTH_DA-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]           r_wrPtr;
   logic [PW-1:0]           r_rdPtr;
   logic [CW-1:0]           r_count;

   logic                    w_push;
   logic                    w_pop;
   logic [31:0]             w_pageWords;
   logic [31:0]             w_len;
   logic [31:0]             w_count32;

   assign w_count32 = 32'(r_count);
   assign in_ready  = r_busy & (w_count32 < 32'(FIFO_DEPTH)) & (r_acc != 32'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = r_wValid & m_axi.M_WREADY;

   // Beats in the next burst: capped by the burst limit, the words left, and the 4 KB page end.
   always_comb begin
      w_pageWords = (32'd4096 - {20'd0, r_addr[11:0]}) >> 2;
      w_len       = 32'(MAX_BURST);
      if (r_rem < w_len) begin
         w_len = r_rem;
      end
      if (w_pageWords < w_len) begin
         w_len = w_pageWords;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_rem     <= '0;
         r_acc     <= '0;
         r_len     <= '0;
         r_awLen   <= '0;
         r_beat    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_awValid <= 1'b0;
         r_wValid  <= 1'b0;
         r_wLast   <= 1'b0;
         r_bReady  <= 1'b0;
      end else begin
         if (w_push) begin
            r_acc <= r_acc - 32'd1;
         end
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_addr  <= base_addr & ~AXI_WIDTH_AD'(3);
                  r_rem   <= num_words;
                  r_acc   <= num_words;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_WAIT;
               end
            end
            // A burst is only announced once every one of its beats sits in the FIFO.
            S_WAIT: begin
               if (r_rem == 32'd0) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (w_count32 >= w_len) begin
                  r_len     <= w_len[8:0];
                  r_awLen   <= 8'(w_len - 32'd1);
                  r_awValid <= 1'b1;
                  r_state   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (m_axi.M_AWREADY) begin
                  r_awValid <= 1'b0;
                  r_wValid  <= 1'b1;
                  r_beat    <= '0;
                  r_wLast   <= (r_len == 9'd1);
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (m_axi.M_WREADY) begin
                  if (r_wLast) begin
                     r_wValid <= 1'b0;
                     r_wLast  <= 1'b0;
                     r_bReady <= 1'b1;
                     r_state  <= S_RESP;
                  end else begin
                     r_beat  <= r_beat + 9'd1;
                     r_wLast <= ((r_beat + 9'd2) == r_len);
                  end
               end
            end
            S_RESP: begin
               if (m_axi.M_BVALID) begin
                  r_bReady <= 1'b0;
                  r_err    <= r_err | (m_axi.M_BRESP != 2'b00);
                  r_addr   <= r_addr + AXI_WIDTH_AD'({r_len, 2'b00});
                  r_rem    <= r_rem - 32'(r_len);
                  if (r_rem == 32'(r_len)) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;

   assign m_axi.M_AWVALID = r_awValid;
   assign m_axi.M_AWADDR  = r_addr;
   assign m_axi.M_AWID    = {AXI_WIDTH_ID{1'b0}};
   assign m_axi.M_AWLEN   = r_awLen;
   assign m_axi.M_AWSIZE  = 3'b010;
   assign m_axi.M_AWBURST = 2'b01;
   assign m_axi.M_AWLOCK  = 2'b00;
   assign m_axi.M_AWCACHE = 4'b0011;
   assign m_axi.M_AWPROT  = 3'b000;

   // Data is gated so the bus reads all zeros whenever no beat is being offered.
   assign m_axi.M_WVALID  = r_wValid;
   assign m_axi.M_WDATA   = r_wValid ? r_mem[r_rdPtr] : '0;
   assign m_axi.M_WSTRB   = {AXI_WIDTH_DS{1'b1}};
   assign m_axi.M_WLAST   = r_wLast;
   assign m_axi.M_WID     = {AXI_WIDTH_ID{1'b0}};

   assign m_axi.M_BREADY  = r_bReady;

endmodule
